// File: rtl/disp_frame_ram.sv
// disp_frame_ram: single-clock frame buffer with power-up clear engine.
// Optional macro DISP_FRAME_RAM_BYPASS_EN selects write-first same-address reads.
module disp_frame_ram #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 17,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear sequencer: sweeps every address once, then hands over to users.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {ADDR_W{1'b1}}) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Single write port shared by the clear engine and the user side.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= CLEAR_VAL;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // Registered read port; data holds between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (state == IDLE && rd_en) begin
            rd_valid <= 1'b1;
`ifdef DISP_FRAME_RAM_BYPASS_EN
            if (wr_en && wr_addr == rd_addr) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
`else
            rd_data  <= mem[rd_addr];
`endif
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_frame_ram.sv
// Self-checking bench for disp_frame_ram (ADDR_W=4, DATA_W=8, CLEAR_VAL=A5).
// Directed scenarios followed by randomized traffic against a reference model.
module tb_disp_frame_ram;

    localparam int         DW    = 8;
    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] CV    = 8'hA5;

`ifdef DISP_FRAME_RAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;

    disp_frame_ram #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .CLEAR_VAL(CV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0] ref_mem [DEPTH];
    int         clear_left = 0;
    logic [7:0] exp_data   = '0;
    logic       exp_valid  = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // one clock: drive inputs, apply the model at the edge, then compare
    task automatic step(input logic r, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic re,
                        input logic [3:0] ra);
        rst     = r;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        if (r) begin
            clear_left = DEPTH;
            exp_valid  = 1'b0;
            exp_data   = '0;
        end else if (clear_left > 0) begin
            ref_mem[DEPTH - clear_left] = CV;
            clear_left--;
            exp_valid = 1'b0;
        end else begin
            exp_valid = re;
            if (re) begin
                if (BYPASS && we && wa == ra) exp_data = wd;
                else exp_data = ref_mem[ra];
            end
            if (we) ref_mem[wa] = wd;
        end
        #1;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
        check("rd_data", {24'd0, rd_data}, {24'd0, exp_data});
        check("busy", {31'd0, busy}, {31'd0, clear_left > 0});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    // counts busy cycles until clear ends, bounded
    task automatic wait_clear(output int bc);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            bc++;
            idle();
        end
    endtask

    int bc;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // reset and initial clear
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        wait_clear(bc);
        check("clear_len", bc, 16);

        // every word reads back the clear value
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(a));
            check("clr_rd", {24'd0, rd_data}, {24'd0, CV});
        end

        // write then read, then hold
        step(1'b0, 1'b1, 4'd5, 8'h3C, 1'b0, 4'd0);
        check("wr_no_valid", {31'd0, rd_valid}, 32'd0);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5);
        check("rd5", {24'd0, rd_data}, 32'h3C);
        check("rd5_valid", {31'd0, rd_valid}, 32'd1);
        idle();
        check("rd5_hold", {24'd0, rd_data}, 32'h3C);
        check("rd5_pulse", {31'd0, rd_valid}, 32'd0);

        // same-address read during write
        step(1'b0, 1'b1, 4'd7, 8'h11, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd7, 8'h22, 1'b1, 4'd7);
        check("same_addr", {24'd0, rd_data}, BYPASS ? 32'h22 : 32'h11);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd7);
        check("same_addr_later", {24'd0, rd_data}, 32'h22);

        // user ports ignored while busy
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd3, 8'hFF, 1'b1, 4'd3);
        check("busy_rd_ignored", {31'd0, rd_valid}, 32'd0);
        wait_clear(bc);
        check("clear_len2", bc, 15);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3);
        check("busy_wr_ignored", {24'd0, rd_data}, {24'd0, CV});

        // reset mid-clear restarts the sweep
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        repeat (8) idle();
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        wait_clear(bc);
        check("restart_len", bc, 16);

        // reset in idle rewrites user data and drops the read
        step(1'b0, 1'b1, 4'd2, 8'h01, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd2);
        check("rd2", {24'd0, rd_data}, 32'h01);
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 4'd2);
        check("rst_drop_valid", {31'd0, rd_valid}, 32'd0);
        wait_clear(bc);
        check("clear_len3", bc, 16);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd2);
        check("rd2_cleared", {24'd0, rd_data}, {24'd0, CV});

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 149) == 0,
                 1'($urandom),
                 4'($urandom),
                 8'($urandom),
                 1'($urandom),
                 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/disp_frame_ram.md
DISP_FRAME_RAM -- requirements
Module: disp_frame_ram

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, pixel word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 17, address width; depth is 2**ADDR_W words.
REQ-003 SHALL provide parameter CLEAR_VAL, default 0, DATA_W-bit value written to every word by the clear engine.
REQ-004 SHALL provide port clk, input, 1, the single clock; all logic rising-edge triggered.
REQ-005 SHALL provide port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL provide port wr_en, input, 1, write request.
REQ-007 SHALL provide port wr_addr, input, ADDR_W, write address.
REQ-008 SHALL provide port wr_data, input, DATA_W, write data.
REQ-009 SHALL provide port rd_en, input, 1, read request.
REQ-010 SHALL provide port rd_addr, input, ADDR_W, read address.
REQ-011 SHALL provide port rd_data, output, DATA_W, registered read data.
REQ-012 SHALL provide port rd_valid, output, 1, rd_data updated this cycle.
REQ-013 SHALL provide port busy, output, 1, clear engine active; user ports ignored.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR, IDLE.
REQ-015 In CLEAR: each cycle write CLEAR_VAL to clr_addr, then clr_addr += 1; busy = 1.
REQ-016 CLEAR -> IDLE on the cycle that writes address 2**ADDR_W-1; busy deasserts the next cycle. Clear takes exactly 2**ADDR_W cycles after rst release.
REQ-017 In CLEAR: wr_en and rd_en ignored; memory not written by user; rd_valid stays 0; rd_data holds.
REQ-018 In IDLE: wr_en=1 writes wr_data to wr_addr at the rising edge.
REQ-019 In IDLE: rd_en=1 at edge N drives rd_data = mem[rd_addr] and rd_valid = 1 after edge N (latency 1 cycle).
REQ-020 rd_valid is a per-request pulse: 0 in any cycle whose preceding edge had rd_en=0 or busy=1.
REQ-021 rd_data holds its last value when no read is accepted.
REQ-022 Simultaneous write and read, different addresses: both complete independently in the same cycle.
REQ-023 Simultaneous write and read, same address: returned data per REQ-030/031.
REQ-024 Addresses are unsigned, full range used; no out-of-range condition; clr_addr wraps only on exit from CLEAR.
REQ-025 Memory contents SHALL NOT be altered other than by REQ-015 and REQ-018.

Reset
REQ-026 rst=1 at an edge: state = CLEAR, clr_addr = 0, rd_data = 0, rd_valid = 0, busy = 1.
REQ-027 rst mid-clear restarts the clear from address 0.
REQ-028 rst during IDLE discards in-flight read (rd_valid = 0 next cycle) and starts a full clear.
REQ-029 While rst=1 no user write occurs; clear writes are permitted.

Configuration
REQ-030 Macro DISP_FRAME_RAM_BYPASS_EN defined: same-address read during write returns new data wr_data (write-first bypass).
REQ-031 Macro undefined: same-address read during write returns old stored data (read-first); no bypass logic present.

Verification (run with ADDR_W=4, DATA_W=8, CLEAR_VAL=8'hA5)
REQ-032 Release rst, hold user ports idle -> busy=1 for exactly 16 cycles then 0; read all 16 addresses -> each returns 8'hA5 with rd_valid pulse 1 cycle after rd_en.
REQ-033 After clear, write 8'h3C @ addr 5, next cycle read addr 5 -> rd_data=8'h3C, rd_valid=1 exactly one cycle after rd_en; rd_data holds with rd_valid=0 afterwards.
REQ-034 Addr 7 holds 8'h11; same cycle wr_en addr 7 data 8'h22 and rd_en addr 7 -> rd_data=8'h11 without macro, 8'h22 with DISP_FRAME_RAM_BYPASS_EN; later read -> 8'h22 both builds.
REQ-035 During busy, issue wr_en addr 3 data 8'hFF and rd_en addr 3 -> rd_valid stays 0; after clear, read addr 3 -> 8'hA5.
REQ-036 Assert rst for 1 cycle at clear cycle 8 -> busy stays 1 for 16 further cycles; write 8'h01 @ addr 2 in IDLE, then rst -> after new clear addr 2 reads 8'hA5.
